// File: rtl/seg7_hex_decode.sv
// ---------------------------------------------------------------------------
// seg7_hex_decode
//
// Purpose:
//   Display loopback checker. It samples the two active-low 7-segment buses
//   that drive HEX1/HEX0 and decodes them back into the 5-bit value 0x00-0x1F
//   that the two-digit hex display encoder was showing.
//
//   A pattern is reported only after it has been seen on STABLE_CYCLES
//   consecutive samples. Each new legal value is presented once on a
//   valid/ready handshake. An illegal stable pattern raises a one-cycle
//   out_err pulse and bumps a saturating error counter.
//
// Parameters:
//   STABLE_CYCLES : identical consecutive samples needed before a decode
//                   (legal range 1..15, default 4)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   seg1[6:0]  in   upper digit segments, active-low, bit6=g .. bit0=a
//   seg0[6:0]  in   lower digit segments, same encoding
//   out_ready  in   consumer accepts out_value while out_valid is high
//   out_valid  out  out_value holds a decoded value
//   out_value  out  decoded value {upper digit bit, lower nibble}
//   out_err    out  one-cycle pulse when a stable pattern is illegal
//   err_count  out  number of illegal patterns, saturates at 255
//
// Build option:
//   SEG7_DEC_BLANK_EN - when defined, a blank upper digit (7'b1111111, as
//   produced by leading-zero suppression) decodes as upper digit 0. When
//   undefined, a blank upper digit is illegal. A blank lower digit is
//   illegal in both builds.
// ---------------------------------------------------------------------------
module seg7_hex_decode #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] seg1,
  input  logic [6:0] seg0,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [4:0] out_value,
  output logic       out_err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_PRESENT,
    ST_LOCKED
  } state_t;

  localparam logic [3:0]  CNT_LIM   = 4'(STABLE_CYCLES);
  localparam logic [13:0] ALL_BLANK = 14'h3FFF;

  state_t      state;
  state_t      state_nxt;
  logic [13:0] samp;
  logic [13:0] capt;
  logic [13:0] capt_nxt;
  logic [3:0]  cnt;

  logic        valid_nxt;
  logic [4:0]  value_nxt;
  logic        err_nxt;
  logic [7:0]  errcnt_nxt;

  logic [1:0]  upper_dec;
  logic [4:0]  lower_dec;
  logic        decode_ok;

  // Upper digit decode: returns {legal, digit bit}.
  function automatic logic [1:0] decode_upper(input logic [6:0] pat);
    logic [1:0] res;
    case (pat)
      7'b1000000: res = 2'b10;
      7'b1111001: res = 2'b11;
`ifdef SEG7_DEC_BLANK_EN
      7'b1111111: res = 2'b10;
`else
      7'b1111111: res = 2'b00;
`endif
      default:    res = 2'b00;
    endcase
    return res;
  endfunction

  // Lower digit decode: returns {legal, nibble}.
  function automatic logic [4:0] decode_lower(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'b1000000: res = 5'h10;
      7'b1111001: res = 5'h11;
      7'b0100100: res = 5'h12;
      7'b0110000: res = 5'h13;
      7'b0011001: res = 5'h14;
      7'b0010010: res = 5'h15;
      7'b0000010: res = 5'h16;
      7'b1111000: res = 5'h17;
      7'b0000000: res = 5'h18;
      7'b0010000: res = 5'h19;
      7'b0001000: res = 5'h1A;
      7'b0000011: res = 5'h1B;
      7'b1000110: res = 5'h1C;
      7'b0100001: res = 5'h1D;
      7'b0000110: res = 5'h1E;
      7'b0001110: res = 5'h1F;
      default:    res = 5'h00;
    endcase
    return res;
  endfunction

  // Input stage: register both buses every cycle and track how long the
  // sample has been unchanged. The comparison uses the incoming value against
  // the current sample so the counter reads 1 on the first cycle a new
  // pattern is held in samp.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      samp <= ALL_BLANK;
      cnt  <= 4'd0;
    end else begin
      samp <= {seg1, seg0};
      if ({seg1, seg0} != samp) begin
        cnt <= 4'd1;
      end else if (cnt < CNT_LIM) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign upper_dec = decode_upper(samp[13:7]);
  assign lower_dec = decode_lower(samp[6:0]);
  assign decode_ok = upper_dec[1] & lower_dec[4];

  // State, capture and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_WAIT;
      capt      <= ALL_BLANK;
      out_valid <= 1'b0;
      out_value <= 5'd0;
      out_err   <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state     <= state_nxt;
      capt      <= capt_nxt;
      out_valid <= valid_nxt;
      out_value <= value_nxt;
      out_err   <= err_nxt;
      err_count <= errcnt_nxt;
    end
  end

  // Next-state and next-output logic. Outputs hold by default; out_err is a
  // pulse so it defaults low. LOCKED waits for the sample to move away from
  // the captured pattern, which is what stops a held pattern from being
  // reported again.
  always_comb begin
    state_nxt  = state;
    capt_nxt   = capt;
    valid_nxt  = out_valid;
    value_nxt  = out_value;
    err_nxt    = 1'b0;
    errcnt_nxt = err_count;

    case (state)
      ST_WAIT: begin
        if (cnt == CNT_LIM) begin
          capt_nxt = samp;
          if (decode_ok) begin
            valid_nxt = 1'b1;
            value_nxt = {upper_dec[0], lower_dec[3:0]};
            state_nxt = ST_PRESENT;
          end else begin
            err_nxt = 1'b1;
            if (err_count != 8'hFF) begin
              errcnt_nxt = err_count + 8'd1;
            end
            state_nxt = ST_LOCKED;
          end
        end
      end

      // out_valid is high throughout this state, so out_ready alone marks
      // the transfer; input activity is ignored until after the handshake.
      ST_PRESENT: begin
        if (out_ready) begin
          valid_nxt = 1'b0;
          state_nxt = ST_LOCKED;
        end
      end

      ST_LOCKED: begin
        if (samp != capt) begin
          state_nxt = ST_WAIT;
        end
      end

      default: begin
        state_nxt = ST_WAIT;
      end
    endcase
  end

endmodule

// File: doc/seg7_hex_decode.md
# seg7_hex_decode

- Decodes the two active-low 7-segment patterns driven onto HEX1/HEX0 back into a 5-bit value (0x00–0x1F), the inverse of the two-digit hex display encoder.
- Serves as a display loopback checker:
  - samples the segment buses;
  - requires a pattern to be stable before reporting it;
  - presents each new legal value once on a valid/ready handshake;
  - flags and counts illegal patterns.

## Interface

Parameters:
- STABLE_CYCLES, default 4: consecutive identical samples required before a pattern is decoded; legal range 1–15.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- seg1, input, 7: upper digit segments. Active-low (0 = lit). Bit 6 = g … bit 0 = a.
- seg0, input, 7: lower digit segments, same encoding as seg1.
- out_ready, input, 1: consumer accepts out_value when high with out_valid.
- out_valid, output, 1: out_value holds a decoded value.
- out_value, output, 5: decoded value, computed as {upper digit bit, lower nibble}.
- out_err, output, 1: one-cycle pulse when a stable pattern is illegal.
- err_count, output, 8: count of illegal patterns; saturates at 255.

## Operation

- Input stage registers {seg1, seg0} every cycle into a 14-bit sample S. A stability counter CNT (4 bits) tracks it:
  - if S differs from the previous S, CNT loads 1;
  - otherwise CNT increments, saturating at STABLE_CYCLES.
- Legal upper patterns:
  - 7'b1000000 → 0
  - 7'b1111001 → 1
- Legal lower patterns, 0–F:
  - 1000000, 1111001, 0100100, 0110000
  - 0011001, 0010010, 0000010, 1111000
  - 0000000, 0010000, 0001000, 0000011
  - 1000110, 0100001, 0000110, 0001110
- Any other pattern on either digit is illegal.
- FSM states:
  - WAIT: on the cycle CNT reaches STABLE_CYCLES, latch S into capture register C and decode it.
    - Legal → PRESENT, with out_valid=1 and out_value loaded.
    - Illegal → LOCKED, with out_err=1 for one cycle and err_count+1 (saturating).
  - PRESENT: out_valid and out_value are held constant regardless of input activity.
    - out_valid && out_ready → LOCKED; out_valid=0 on the next cycle.
  - LOCKED: if S ≠ C → WAIT. The stability count restarts from the new sample, so a stable pattern is never reported twice.
- In PRESENT, an input change does not abort the transfer. After the handshake, LOCKED compares S against C and returns to WAIT if they differ.
- err_count at 255 stays at 255; out_err still pulses.

## Timing

- Reset values:
  - out_valid=0, out_value=0, out_err=0, err_count=0
  - state=WAIT, CNT=0
  - S=C=14'h3FFF (both digits blank)
- Reset mid-operation: all state and outputs return to reset values on the next edge. Any in-flight value is dropped.
- Latency: a pattern first applied before edge k and held is first sampled at edge k. out_valid rises after edge k+STABLE_CYCLES (seen high from edge k+STABLE_CYCLES+1).
- out_err pulses in the same cycle out_valid would have risen for a legal pattern.
- Handshake:
  - out_value is stable while out_valid=1;
  - a transfer occurs on any edge with out_valid && out_ready;
  - out_ready may be held high permanently, giving a one-cycle valid pulse per pattern;
  - out_ready has no effect outside PRESENT.
- Glitches shorter than STABLE_CYCLES samples produce neither valid nor err.

## Configuration

- SEG7_DEC_BLANK_EN:
  - When defined: an upper pattern of 7'b1111111 (blank, leading-zero suppression) decodes as upper digit 0.
  - When undefined: a blank upper digit is illegal.
- A blank lower digit is illegal in both builds.

## Test plan

1. Reset; seg1=1000000, seg0=0100100 held; out_ready=1 → out_valid high exactly one cycle, 5 cycles after first sample edge (STABLE_CYCLES=4), out_value=2. No further valid while held.
2. seg1=1111001, seg0=0001110 held; out_ready=0 for 10 cycles → out_valid held with out_value=31 throughout. Raising out_ready drops out_valid next cycle.
3. seg0 toggles 0x1↔0x2 patterns every 2 cycles for 20 cycles → no valid, no err. Then hold 0x2 → exactly one valid, value 2.
4. seg0=1111111 held → out_err one pulse, err_count=1, no valid. Change to 0110110 → err_count=2. Apply 300 distinct illegal episodes → err_count=255.
5. seg1=1111111, seg0=1111001 → with SEG7_DEC_BLANK_EN: valid, value 1. Without it: out_err pulse, no valid.
6. reset_n low one cycle while out_valid=1 → out_valid=0 and err_count=0 after the edge. The held pattern is re-reported STABLE_CYCLES+1 cycles later.
